fib_capture_fifo: RTL
=====================

// Module: fib_capture_fifo
// PURPOSE
//  Downstream consumer of the fibonacci counter output. Synchronises the
//  30-bit value into wb_clk_i, detects each new settled value and queues it
//  in a small FIFO. Firmware drains the FIFO over Wishbone, and irq_o
//  flags a fill threshold. Only settled values are recorded.
// PARAMETERS
//  WIDTH      30            width of value_i (zero-extended to 32 on read)
//  DEPTH      8             FIFO entries, power of two, >=2
//  BASE_ADDR  32'h3000_0100 Wishbone base; block decodes adr[31:4]
// PORTS
//  wb_clk_i   in   1      sole clock
//  reset      in   1      asynchronous, active-high
//  value_i    in   WIDTH  fibonacci value, generated on a divided clock
//  wbs_stb_i  in   1      Wishbone strobe
//  wbs_cyc_i  in   1      Wishbone cycle
//  wbs_we_i   in   1      1 = write
//  wbs_sel_i  in   4      byte selects; writes need all four set (4'hF)
//  wbs_dat_i  in   32     write data
//  wbs_adr_i  in   32     byte address
//  wbs_ack_o  out  1      single-cycle acknowledge
//  wbs_dat_o  out  32     read data
//  irq_o      out  1      level interrupt: FIFO count >= threshold
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; enable=1; thresh=0; overflow=0;
//   drops=0; last=0; sync flops 0.
//  Capture: 2-flop sync s1->s2. Candidate = s2 when s2==s1 (stable >=1
//   cycle). Push when enable && candidate!=last; then last<=candidate.
//   Latency value_i change -> FIFO visible: 3 cycles.
//   Wrap or restart of the counter is just another change and is pushed.
//  Full: a push while full is dropped. overflow<=1 (sticky).
//   drops increments and saturates at 16'hFFFF. last still updates.
//  Same cycle push and pop: both take effect, count unchanged, even when
//   full. When empty, only the push happens.
//  Registers (offset = adr[3:0]):
//   0x0 DATA   R: pops head, returns {0,entry}. If empty: 0, no pop.
//              W: ignored, acked.
//   0x4 STATUS R: {16'b0, count[7:0], 5'b0, overflow, full, empty}
//   0x8 CTRL   R/W: bit0 enable, bits[11:8] thresh.
//              Write bit1=1 flushes: FIFO empty, overflow=0, drops=0.
//              Flush wins over a same-cycle push. last is kept.
//   0xC DROPS  R: {16'b0, drops}
//  Handshake: a request is stb&cyc&adr[31:4]==BASE_ADDR[31:4]. ack_o and
//   dat_o are registered 1 cycle after the request. ack drops the next
//   cycle even if stb stays high, so each request yields one ack.
//   A request is not re-acked while ack_o=1. Side effects (pop, CTRL
//   write) occur once, in the ack cycle. A non-matching address gets
//   no ack. dat_o=0 whenever ack_o=0.
//  irq_o registered: (thresh!=0) && (count>=thresh); updates 1 cycle
//   after count changes.
//  Reset mid-transfer: ack_o and FIFO clear immediately. No pending ack
//   survives reset.
// STRUCTURE
//  Package fib_capture_pkg: register offsets (OFS_DATA/STATUS/CTRL/DROPS),
//   CTRL bit positions, DROPS_MAX=16'hFFFF.
//  Sub-module sync_fifo #(W,DEPTH): ptr+1-bit wrap, push/pop/flush,
//   count/full/empty. Sync, change detect and Wishbone decode live in
//   the top.
// TESTING
//  1 Reset, then read STATUS -> 32'h0000_0001 (empty). Read DATA -> 0.
//    irq_o=0.
//  2 value_i 1,2,3,5 each held 4 cycles -> DATA reads return 1,2,3,5 in
//    order, then empty.
//  3 Glitch: value_i 8 held 1 cycle then back to 5 -> no entry for 8.
//  4 Push 10 distinct values, no reads -> count=8, full=1, overflow=1,
//    DROPS=2. Flush -> STATUS=1, DROPS=0.
//  5 CTRL thresh=3: after 3rd push irq_o=1 one cycle later. One DATA
//    pop -> irq_o=0.
//  6 Hold stb for 3 cycles on DATA -> exactly one ack and one pop.
//    Assert reset mid-ack -> ack_o=0 and count=0 that cycle.

Source files
------------

// File: rtl/fib_capture_pkg.sv
// Shared register map and control-field layout for the fibonacci capture FIFO.
package fib_capture_pkg;

  typedef enum logic [3:0] {
    OFS_DATA   = 4'h0,
    OFS_STATUS = 4'h4,
    OFS_CTRL   = 4'h8,
    OFS_DROPS  = 4'hC
  } reg_ofs_e;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;
  localparam int unsigned CTRL_THR_LSB   = 8;
  localparam int unsigned CTRL_THR_MSB   = 11;

  localparam logic [15:0] DROPS_MAX = 16'hFFFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra wrap bit on the pointers; flush overrides push/pop.
module sync_fifo #(
  parameter int unsigned W     = 30,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_push;
  logic         w_pop;

  assign o_count = r_wr - r_rd;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_dout  = r_mem[r_rd[AW-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/fib_capture_fifo.sv
// Synchronises the fibonacci value, queues each new settled value, and exposes
// the queue, status, control and drop counter over a Wishbone slave port.
module fib_capture_fifo
  import fib_capture_pkg::*;
#(
  parameter int unsigned WIDTH     = 30,
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
  input  logic             wb_clk_i,
  input  logic             reset,
  input  logic [WIDTH-1:0] value_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             irq_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_s1, r_s2, r_last;
  logic             r_en;
  logic [3:0]       r_thr;
  logic             r_ovf;
  logic [15:0]      r_drops;
  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_irq;
  logic             r_req_q;

  logic [WIDTH-1:0] w_dout;
  logic [CW-1:0]    w_count;
  logic             w_full, w_empty;
  logic             w_push, w_pop, w_flush, w_drop;
  logic             w_req, w_issue, w_ctrl_wr;
  logic [3:0]       w_ofs;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_push = r_en && (r_s2 == r_s1) && (r_s2 != r_last);

  // Only the rising edge of a request is served, so a strobe held past its ack gets one ack.
  assign w_req     = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_issue   = w_req && !r_req_q && !r_ack;
  assign w_ofs     = wbs_adr_i[3:0];
  assign w_ctrl_wr = w_issue && wbs_we_i && (wbs_sel_i == 4'hF) && (w_ofs == OFS_CTRL);
  assign w_flush   = w_ctrl_wr && wbs_dat_i[CTRL_FLUSH_BIT];
  assign w_pop     = w_issue && !wbs_we_i && (w_ofs == OFS_DATA);
  assign w_drop    = w_push && w_full && !w_pop && !w_flush;
  assign w_unused  = ^{wbs_dat_i[31:12], wbs_dat_i[7:2]};

  sync_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (wb_clk_i),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (r_s2),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_DATA:   w_rdata = w_empty ? '0 : 32'(w_dout);
      OFS_STATUS: w_rdata = {16'h0, 8'(w_count), 5'b0, r_ovf, w_full, w_empty};
      OFS_CTRL:   w_rdata = {20'h0, r_thr, 7'b0, r_en};
      OFS_DROPS:  w_rdata = {16'h0, r_drops};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge reset) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_last  <= '0;
      r_en    <= 1'b1;
      r_thr   <= '0;
      r_ovf   <= 1'b0;
      r_drops <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
      r_irq   <= 1'b0;
      r_req_q <= 1'b0;
    end else begin
      r_s1    <= value_i;
      r_s2    <= r_s1;
      r_req_q <= w_req;
      r_ack   <= w_issue;
      r_dat   <= (w_issue && !wbs_we_i) ? w_rdata : '0;
      r_irq   <= (r_thr != 4'd0) && (8'(w_count) >= 8'(r_thr));
      if (w_push) r_last <= r_s2;
      if (w_ctrl_wr) begin
        r_en  <= wbs_dat_i[CTRL_EN_BIT];
        r_thr <= wbs_dat_i[CTRL_THR_MSB:CTRL_THR_LSB];
      end
      if (w_flush) begin
        r_ovf   <= 1'b0;
        r_drops <= '0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drops != DROPS_MAX) r_drops <= r_drops + 16'd1;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;

endmodule
